// File: rtl/seq_alu_exec_pkg.sv
// Shared constants for the multi-cycle ALU execution unit: ALU select codes,
// FSM state encodings, and a helper that classifies shift operations.
package seq_alu_exec_pkg;

    // ALU select codes produced by ALU control decode
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLT  = 4'h5;
    localparam logic [3:0] ALU_SLTU = 4'h6;
    localparam logic [3:0] ALU_SLL  = 4'h7;
    localparam logic [3:0] ALU_SRL  = 4'h8;
    localparam logic [3:0] ALU_SRA  = 4'h9;
    localparam logic [3:0] ALU_SRAI = 4'hA;
    localparam logic [3:0] ALU_PASS = 4'hB;

    // Execution FSM states
    localparam logic [1:0] EXE_IDLE  = 2'd0;
    localparam logic [1:0] EXE_SHIFT = 2'd1;
    localparam logic [1:0] EXE_DONE  = 2'd2;

    typedef enum logic [1:0] {
        SH_NONE  = 2'd0,
        SH_LEFT  = 2'd1,
        SH_RIGHT = 2'd2,
        SH_ARITH = 2'd3
    } shift_kind_e;

    // SRA and SRAI behave identically: both sign-fill from the original MSB
    function automatic shift_kind_e shift_kind(input logic [3:0] sel);
        case (sel)
            ALU_SLL:           return SH_LEFT;
            ALU_SRL:           return SH_RIGHT;
            ALU_SRA, ALU_SRAI: return SH_ARITH;
            default:           return SH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/seq_alu_exec_if.sv
// Request/response bundle between the operand stage, the execution unit and
// writeback/branch logic. The execution unit is the slave.
interface seq_alu_exec_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_sel;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero_flag;
    logic             carry_flag;
    logic             ovf_flag;
    logic             sign_flag;

    modport master (
        output in_valid, alu_sel, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero_flag, carry_flag, ovf_flag, sign_flag
    );

    modport slave (
        input  in_valid, alu_sel, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero_flag, carry_flag, ovf_flag, sign_flag
    );
endinterface

// File: rtl/seq_alu_exec_serial_shifter.sv
// Serial 1-bit-per-cycle shifter. Loaded with data and a shift amount, it
// shifts once per cycle until the counter runs out. o_done flags the cycle
// in which the final shift lands; o_next is the value after that shift.
module seq_alu_exec_serial_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_dir,     // 1 = right, 0 = left
    input  logic               i_arith,   // right shifts fill with data MSB
    input  logic [WIDTH-1:0]   i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic [WIDTH-1:0]   o_next,
    output logic               o_done
);
    logic [WIDTH-1:0]   r_data;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_dir;
    logic               r_fill;

    assign o_next = r_dir ? {r_fill, r_data[WIDTH-1:1]} : {r_data[WIDTH-2:0], 1'b0};
    assign o_done = (r_cnt == SHAMT_W'(1));

    // Load operand and count on request, then shift one bit per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_cnt  <= '0;
            r_dir  <= 1'b0;
            r_fill <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_cnt  <= i_shamt;
            r_dir  <= i_dir;
            r_fill <= i_arith & i_data[WIDTH-1];
        end else if (r_cnt != '0) begin
            r_data <= o_next;
            r_cnt  <= r_cnt - SHAMT_W'(1);
        end
    end
endmodule

// File: rtl/seq_alu_exec.sv
// Multi-cycle ALU execution unit. Logic/arithmetic ops finish one cycle after
// capture; non-zero shifts go through the serial shifter (shamt+1 cycles).
// Results and flags are registered and held until the next op writes them.
module seq_alu_exec
    import seq_alu_exec_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    seq_alu_exec_if.slave bus
);
    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero, r_carry, r_ovf, r_sign;

    logic [WIDTH:0]     w_sum, w_diff;
    logic [WIDTH-1:0]   w_res, w_fin_res, w_sh_next;
    logic               w_carry, w_ovf, w_fin_carry, w_fin_ovf;
    logic [SHAMT_W-1:0] w_shamt;
    shift_kind_e        w_kind;
    logic               w_capture, w_sh_load, w_sh_done, w_in_shift, w_wr;

    assign w_shamt   = bus.op_b[SHAMT_W-1:0];
    assign w_kind    = shift_kind(bus.alu_sel);
    assign w_sum     = {1'b0, bus.op_a} + {1'b0, bus.op_b};
    assign w_diff    = {1'b0, bus.op_a} - {1'b0, bus.op_b};
    assign w_capture = bus.in_valid && (r_state == EXE_IDLE);
    assign w_sh_load = w_capture && (w_kind != SH_NONE) && (w_shamt != '0);
    assign w_in_shift = (r_state == EXE_SHIFT);

    // Single-cycle result; a zero-amount shift just passes op_a through
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (bus.alu_sel)
            ALU_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != bus.op_a[WIDTH-1]);
            end
            ALU_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = ~w_diff[WIDTH];
                w_ovf   = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) &&
                          (w_diff[WIDTH-1] != bus.op_a[WIDTH-1]);
            end
            ALU_AND:  w_res = bus.op_a & bus.op_b;
            ALU_OR:   w_res = bus.op_a | bus.op_b;
            ALU_XOR:  w_res = bus.op_a ^ bus.op_b;
            ALU_SLT:  w_res = {{(WIDTH-1){1'b0}}, $signed(bus.op_a) < $signed(bus.op_b)};
            ALU_SLTU: w_res = {{(WIDTH-1){1'b0}}, bus.op_a < bus.op_b};
            ALU_SLL, ALU_SRL, ALU_SRA, ALU_SRAI: w_res = bus.op_a;
            ALU_PASS: w_res = bus.op_b;
            default:  w_res = '0;
        endcase
    end

    seq_alu_exec_serial_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shifter (
        .clk     (clk),
        .rst_n   (rst),
        .i_load  (w_sh_load),
        .i_dir   (w_kind != SH_LEFT),
        .i_arith (w_kind == SH_ARITH),
        .i_data  (bus.op_a),
        .i_shamt (w_shamt),
        .o_next  (w_sh_next),
        .o_done  (w_sh_done)
    );

    // Result registers are written either at capture (single-cycle ops) or
    // when the last shift lands; shifts never produce carry/overflow
    assign w_fin_res   = w_in_shift ? w_sh_next : w_res;
    assign w_fin_carry = !w_in_shift && w_carry;
    assign w_fin_ovf   = !w_in_shift && w_ovf;
    assign w_wr        = (w_capture && !w_sh_load) || (w_in_shift && w_sh_done);

    // Control FSM: IDLE -> (SHIFT) -> DONE -> IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= EXE_IDLE;
        end else begin
            case (r_state)
                EXE_IDLE:  if (w_capture) r_state <= w_sh_load ? EXE_SHIFT : EXE_DONE;
                EXE_SHIFT: if (w_sh_done) r_state <= EXE_DONE;
                EXE_DONE:  if (bus.out_ready) r_state <= EXE_IDLE;
                default:   r_state <= EXE_IDLE;
            endcase
        end
    end

    // Registered result and flags, held until the next op completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_sign   <= 1'b0;
        end else if (w_wr) begin
            r_result <= w_fin_res;
            r_zero   <= (w_fin_res == '0);
            r_carry  <= w_fin_carry;
            r_ovf    <= w_fin_ovf;
            r_sign   <= w_fin_res[WIDTH-1];
        end
    end

    // in_ready is forced low while reset is asserted
    assign bus.in_ready   = rst && (r_state == EXE_IDLE);
    assign bus.out_valid  = (r_state == EXE_DONE);
    assign bus.result     = r_result;
    assign bus.zero_flag  = r_zero;
    assign bus.carry_flag = r_carry;
    assign bus.ovf_flag   = r_ovf;
    assign bus.sign_flag  = r_sign;
endmodule

// File: doc/seq_alu_exec.md
Name: seq_alu_exec

Overview:
- Multi-cycle ALU execution unit; consumes the 4-bit ALU selection produced by ALU control decode, plus two operands.
- Returns the result and flags over valid/ready handshakes. Sits between the decode/operand stage and writeback/branch logic.
- Logic and arithmetic ops complete in 1 cycle; shifts run through a serial 1-bit-per-cycle shifter to save area.

Parameters:
- WIDTH, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; equals log2(WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  unit can accept a request.
- alu_sel  in  4  operation code; `ALU_* macros from defines.v.
- op_a  in  WIDTH  first operand (rs1 / PC).
- op_b  in  WIDTH  second operand (rs2 / immediate); shift amount is op_b[SHAMT_W-1:0].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  operation result.
- zero_flag  out  1  result == 0.
- carry_flag  out  1  carry out of ADD; no-borrow (a >= b unsigned) for SUB; 0 otherwise.
- ovf_flag  out  1  signed overflow of ADD/SUB; 0 otherwise.
- sign_flag  out  1  result[WIDTH-1].

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; in_ready=0 while asserted; out_valid=0; result=0; all flags=0; shift counter=0.
- States:
  - IDLE: in_ready=1. On in_valid, capture alu_sel, op_a, op_b.
  - IDLE -> SHIFT if op is SLL, SRL, SRA or SRAI and shamt != 0.
  - IDLE -> DONE otherwise. DONE holds the computed result.
  - SHIFT: each cycle shifts the working register by 1 bit and decrements the counter. When the counter reaches 1, the final shift lands and the state moves to DONE.
  - DONE: out_valid=1. Advance to IDLE when out_ready=1.
- Latency, capture edge to out_valid: 1 cycle for non-shift ops and shamt=0; shamt+1 cycles for shifts (shamt=31 -> 32 cycles).
- in_ready=1 only in IDLE. There is no capture in DONE, even when out_ready=1 that cycle, so peak throughput is 1 op per 2 cycles.
- result and flags are registered. They are held stable while out_valid=1 and out_ready=0, and keep their last value after handshake until the next op writes them.
- Ops:
  - ADD: a+b. SUB: a-b. Both wrap modulo 2^WIDTH.
  - AND, OR, XOR: bitwise.
  - SLT: signed a<b gives 1, else 0, zero-extended. SLTU: unsigned compare.
  - SLL: fill 0. SRL: fill 0. SRA and SRAI: fill with the original a[WIDTH-1]; both are identical here.
  - PASS: result = op_b.
  - Any unlisted code: result=0, flags computed from 0, latency 1.
- Flags:
  - carry and ovf are computed with WIDTH+1 arithmetic for ADD/SUB only; forced 0 for every other op.
  - zero and sign are always derived from the final result.
- Boundaries:
  - Shift uses only op_b[4:0]; op_b=0x25 shifts by 5.
  - in_valid while not in IDLE is ignored; the producer must hold it.
  - Reset in SHIFT or DONE aborts the op; no result is delivered.
  - out_ready asserted with no out_valid has no effect.

Decomposition:
- ALU select codes stay in defines.v. That file already holds `ALU_PASS and all `ALU_* codes; no new codes are added.
- Add state encodings `EXE_IDLE, `EXE_SHIFT, `EXE_DONE (2 bits) to defines.v.
- One natural sub-module: serial_shifter. It holds the working register and down-counter, takes load/dir/arith inputs, and produces done.
- Add/sub, compare and logic stay in the top module.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, out_ready=1 -> out_valid 1 cycle after capture; result=0x80000000, ovf=1, carry=0, sign=1, zero=0.
- SUB 5 - 5, then SLTU 0xFFFFFFFF vs 1 -> first: result=0, zero=1, carry=1. Second: result=0.
- SRA 0x80000000 by op_b=0x1F -> out_valid exactly 32 cycles after capture; result=0xFFFFFFFF. SLL 0x1 by op_b=0x0 -> latency 1, result=0x1.
- Backpressure: XOR 0xF0F0F0F0 ^ 0xFFFF0000 with out_ready=0 for 5 cycles -> result=0x0F0FF0F0 held stable. in_ready=0 throughout; handshake completes when out_ready=1; in_ready=1 the next cycle.
- Reset mid-shift: SRL 0xFFFFFFFF by 20, rst=0 at cycle 7 -> out_valid, result, flags all 0 immediately (asynchronous). After release: in_ready=1; no stale result is delivered.
- PASS with op_b=0x12345000, then unlisted code 4'b1111 -> result=0x12345000 (sign=0); then result=0 with zero=1, both at latency 1.
